// File: rtl/periferico_spi.sv
// SPI peripheral (slave) with a 16-bit word size.
// SCK, SS and MOSI are asynchronous to clk and are resynchronised before use;
// SCK edges are recovered by comparing the synchronised level with its previous value.
// CKP selects the SCK idle level and CPH selects which SCK edge samples and which shifts.
module periferico_spi #(
    parameter bit CKP = 1'b0,
    parameter bit CPH = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCK,
    input  logic        SS,
    input  logic        MOSI,
    input  logic [15:0] tx_data,
    output logic        MISO,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StTransfer,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Synchroniser stages plus one history flop each for edge detection
    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    // Start-of-word gating: SS must be seen high after reset before a fall counts
    logic [1:0] primed_q;
    logic       armed_q;

    logic [3:0]  bit_cnt_q;
    logic [15:0] tx_sr_q;
    logic [15:0] rx_sr_q;
    logic [15:0] rx_data_q;
    logic        rx_valid_q;
    logic        miso_en_q;

    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic ss_fall, last_bit;

    // Two-flop synchronisers and the SS arming logic
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_meta  <= CKP;
            sck_sync  <= CKP;
            sck_prev  <= CKP;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            primed_q  <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sck_meta  <= SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= SS;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
            // primed_q[1] marks when ss_sync first carries a real post-reset sample,
            // so an SS held low through reset cannot look like a fresh falling edge
            primed_q  <= {primed_q[0], 1'b1};
            armed_q   <= armed_q | (primed_q[1] & ss_sync);
        end
    end

    // Edge classification relative to the idle level
    always_comb begin
        lead_edge   = (sck_prev == CKP) && (sck_sync != CKP);
        trail_edge  = (sck_prev != CKP) && (sck_sync == CKP);
        sample_edge = CPH ? trail_edge : lead_edge;
        shift_edge  = CPH ? lead_edge : trail_edge;
        ss_fall     = armed_q && ss_prev && !ss_sync;
        last_bit    = sample_edge && (bit_cnt_q == 4'd15);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        MISO    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StTransfer;
                end
            end
            StTransfer: begin
                busy = 1'b1;
                MISO = miso_en_q & tx_sr_q[15];
                // A word that completes on the same cycle SS rises is still delivered
                if (last_bit) begin
                    state_d = StDone;
                end else if (ss_sync) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                busy    = 1'b1;
                MISO    = miso_en_q & tx_sr_q[15];
                state_d = ss_sync ? StIdle : StTransfer;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Shift registers, bit counter and received-word register
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_q  <= 4'd0;
            tx_sr_q    <= 16'h0000;
            rx_sr_q    <= 16'h0000;
            rx_data_q  <= 16'h0000;
            rx_valid_q <= 1'b0;
            miso_en_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= 4'd0;
                    miso_en_q <= 1'b0;
                    if (ss_fall) begin
                        tx_sr_q   <= tx_data;
                        // CPH=0 drives the MSB straight away; CPH=1 waits for the first leading edge
                        miso_en_q <= ~CPH;
                    end
                end
                StTransfer: begin
                    if (ss_sync && !last_bit) begin
                        bit_cnt_q <= 4'd0;
                    end else begin
                        if (sample_edge) begin
                            rx_sr_q   <= {rx_sr_q[14:0], mosi_sync};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        // With the counter at zero the shift edge belongs to a word boundary
                        // (the first leading edge for CPH=1, the last trailing edge for CPH=0)
                        // and must not disturb the freshly loaded MSB
                        if (shift_edge) begin
                            miso_en_q <= 1'b1;
                            if (bit_cnt_q != 4'd0) begin
                                tx_sr_q <= {tx_sr_q[14:0], 1'b0};
                            end
                        end
                    end
                end
                StDone: begin
                    rx_data_q  <= rx_sr_q;
                    rx_valid_q <= 1'b1;
                    tx_sr_q    <= tx_data;
                end
                default: begin
                    bit_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_periferico_spi.sv
// Bench for periferico_spi: one instance in mode 0 (CKP=0,CPH=0), one in mode 3 (CKP=1,CPH=1).
// A behavioural SPI controller drives words; expected results come from the protocol itself:
// the received word equals the word sent, the MISO stream equals tx_data MSB first.
module tb_periferico_spi;

    localparam int Half = 8;  // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        sck0, ss0, sck3, ss3, mosi;
    logic [15:0] tx0, tx3;
    logic        miso0, miso3, rxv0, rxv3, busy0, busy3;
    logic [15:0] rxd0, rxd3;

    always #5 clk = ~clk;

    periferico_spi #(.CKP(1'b0), .CPH(1'b0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .SCK      (sck0),
        .SS       (ss0),
        .MOSI     (mosi),
        .tx_data  (tx0),
        .MISO     (miso0),
        .rx_data  (rxd0),
        .rx_valid (rxv0),
        .busy     (busy0)
    );

    periferico_spi #(.CKP(1'b1), .CPH(1'b1)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .SCK      (sck3),
        .SS       (ss3),
        .MOSI     (mosi),
        .tx_data  (tx3),
        .MISO     (miso3),
        .rx_data  (rxd3),
        .rx_valid (rxv3),
        .busy     (busy3)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Every rx_valid pulse is logged with the word it carries
    logic [15:0] q0[$];
    logic [15:0] q3[$];
    always @(negedge clk) begin
        if (rxv0) q0.push_back(rxd0);
        if (rxv3) q3.push_back(rxd3);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Controller side of one word (or a partial word of nbits). Mode 0: MOSI set before the
    // leading edge, MISO sampled at it. Mode 3: MOSI set at the leading edge, MISO sampled at
    // the trailing edge. ss_up_last raises SS together with the final sample edge.
    task automatic xfer(input bit m3, input logic [15:0] w, input int nbits,
                        input bit ss_up_last, output logic [15:0] got);
        got = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            if (!m3) begin
                mosi = w[15-i];
                wait_clk(Half);
                sck0 = 1'b1;
                got[15-i] = miso0;
                if (ss_up_last && i == nbits - 1) ss0 = 1'b1;
                wait_clk(Half);
                sck0 = 1'b0;
            end else begin
                sck3 = 1'b0;
                mosi = w[15-i];
                wait_clk(Half);
                sck3 = 1'b1;
                got[15-i] = miso3;
                if (ss_up_last && i == nbits - 1) ss3 = 1'b1;
                wait_clk(Half);
            end
        end
        wait_clk(Half);
    endtask

    task automatic set_ss(input bit m3, input logic v);
        if (m3) ss3 = v;
        else ss0 = v;
    endtask

    // Compare the logged rx words of one instance against the expected list
    task automatic check_rx(input bit m3, input string tag, input logic [15:0] exp[$]);
        int n;
        logic [15:0] w;
        n = m3 ? q3.size() : q0.size();
        check_eq({tag, "_count"}, n, exp.size());
        foreach (exp[k]) begin
            if (m3 ? (q3.size() > 0) : (q0.size() > 0)) begin
                w = m3 ? q3.pop_front() : q0.pop_front();
                check_eq({tag, "_word"}, w, exp[k]);
            end
        end
        q0.delete();
        q3.delete();
    endtask

    logic [15:0] got, w, tx, last0, last3;
    logic [15:0] expq[$];
    bit          m3;
    int          nw;

    initial begin
        reset = 1'b0;
        ss0 = 1'b1; ss3 = 1'b1;
        sck0 = 1'b0; sck3 = 1'b1;
        mosi = 1'b0;
        tx0 = 16'h0000; tx3 = 16'h0000;
        last0 = 16'h0000; last3 = 16'h0000;
        wait_clk(4);

        // Reset state
        check_eq("rst_miso0", miso0, 1'b0);
        check_eq("rst_rxd0", rxd0, 16'h0000);
        check_eq("rst_rxv0", rxv0, 1'b0);
        check_eq("rst_busy0", busy0, 1'b0);
        check_eq("rst_miso3", miso3, 1'b0);
        check_eq("rst_rxd3", rxd3, 16'h0000);
        check_eq("rst_busy3", busy3, 1'b0);
        reset = 1'b1;
        wait_clk(6);

        // Mode 0 single word
        tx0 = 16'hA5C3;
        ss0 = 1'b0;
        wait_clk(4);
        check_eq("m0_busy_start", busy0, 1'b1);
        check_eq("m0_miso_msb", miso0, 1'b1);
        wait_clk(Half - 4);
        xfer(1'b0, 16'h1234, 16, 1'b0, got);
        check_eq("m0_miso_stream", got, 16'hA5C3);
        ss0 = 1'b1;
        wait_clk(Half);
        check_eq("m0_busy_end", busy0, 1'b0);
        expq = '{16'h1234};
        check_rx(1'b0, "m0", expq);
        last0 = 16'h1234;

        // Mode 3 back-to-back words under continuous SS
        tx3 = 16'h8001;
        ss3 = 1'b0;
        wait_clk(Half);
        xfer(1'b1, 16'hFFFF, 16, 1'b0, got);
        check_eq("m3_miso_w1", got, 16'h8001);
        xfer(1'b1, 16'h0001, 16, 1'b0, got);
        check_eq("m3_miso_w2", got, 16'h8001);
        ss3 = 1'b1;
        wait_clk(Half);
        check_eq("m3_busy_end", busy3, 1'b0);
        expq = '{16'hFFFF, 16'h0001};
        check_rx(1'b1, "m3", expq);
        last3 = 16'h0001;

        // Mode 0 abort after 9 bits
        tx0 = 16'($urandom);
        ss0 = 1'b0;
        wait_clk(Half);
        xfer(1'b0, 16'hBEEF, 9, 1'b0, got);
        check_eq("abort_miso_part", got & 16'hFF80, tx0 & 16'hFF80);
        ss0 = 1'b1;
        wait_clk(4);
        check_eq("abort_busy", busy0, 1'b0);
        wait_clk(Half);
        check_eq("abort_rxd_kept", rxd0, last0);
        expq = {};
        check_rx(1'b0, "abort", expq);

        // SCK activity with SS high is ignored
        for (int i = 0; i < 16; i++) begin
            sck0 = ~sck0;
            sck3 = ~sck3;
            mosi = 1'($urandom);
            wait_clk(Half / 2);
        end
        check_eq("ssh_busy0", busy0, 1'b0);
        check_eq("ssh_miso0", miso0, 1'b0);
        check_eq("ssh_busy3", busy3, 1'b0);
        check_eq("ssh_miso3", miso3, 1'b0);
        check_eq("ssh_rxd0", rxd0, last0);
        expq = {};
        check_rx(1'b0, "ssh", expq);

        // Word completing on the same cycle SS rises, both modes
        for (int md = 0; md < 2; md++) begin
            m3 = md[0];
            tx = 16'($urandom);
            w  = 16'($urandom);
            if (m3) tx3 = tx;
            else tx0 = tx;
            set_ss(m3, 1'b0);
            wait_clk(Half);
            xfer(m3, w, 16, 1'b1, got);
            check_eq("edge_ss_miso", got, tx);
            check_eq("edge_ss_busy", m3 ? busy3 : busy0, 1'b0);
            expq = '{w};
            check_rx(m3, "edge_ss", expq);
            if (m3) last3 = w;
            else last0 = w;
        end

        // Reset in the middle of a word, then a fresh word
        tx0 = 16'($urandom);
        ss0 = 1'b0;
        wait_clk(Half);
        xfer(1'b0, 16'($urandom), 8, 1'b0, got);
        reset = 1'b0;
        wait_clk(1);
        check_eq("mrst_miso", miso0, 1'b0);
        check_eq("mrst_rxd", rxd0, 16'h0000);
        check_eq("mrst_rxv", rxv0, 1'b0);
        check_eq("mrst_busy", busy0, 1'b0);
        check_eq("mrst_rxd3", rxd3, 16'h0000);
        reset = 1'b1;
        last0 = 16'h0000;
        last3 = 16'h0000;
        wait_clk(12);
        check_eq("mrst_no_restart", busy0, 1'b0);
        ss0 = 1'b1;
        wait_clk(Half);
        tx0 = 16'($urandom);
        ss0 = 1'b0;
        wait_clk(Half);
        xfer(1'b0, 16'h00FF, 16, 1'b0, got);
        check_eq("mrst_miso_stream", got, tx0);
        ss0 = 1'b1;
        wait_clk(Half);
        expq = '{16'h00FF};
        check_rx(1'b0, "mrst", expq);

        // Random bursts of 1..3 words in either mode
        for (int r = 0; r < 8; r++) begin
            m3 = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            tx = 16'($urandom);
            if (m3) tx3 = tx;
            else tx0 = tx;
            set_ss(m3, 1'b0);
            wait_clk(Half);
            expq = {};
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                expq.push_back(w);
                xfer(m3, w, 16, 1'b0, got);
                check_eq("rnd_miso", got, tx);
            end
            set_ss(m3, 1'b1);
            wait_clk(Half);
            check_eq("rnd_busy", m3 ? busy3 : busy0, 1'b0);
            check_eq("rnd_rxd", m3 ? rxd3 : rxd0, expq[nw-1]);
            check_rx(m3, "rnd", expq);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/periferico_spi.md
PERIFERICO_SPI -- requirements
Module: periferico_spi

Interface
REQ-001 Parameter CKP, default 0, SCK idle level (0: idle low, 1: idle high).
REQ-002 Parameter CPH, default 0, clock phase (0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing).
REQ-003 Port clk  input  1  system clock; all logic on rising edge, single clock domain.
REQ-004 Port reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 Port SCK  input  1  serial clock from the controller, asynchronous to clk.
REQ-006 Port SS  input  1  active-low slave select from the controller, asynchronous to clk.
REQ-007 Port MOSI  input  1  serial data from the controller, MSB first.
REQ-008 Port tx_data  input  16  word to return to the controller, sampled at word start.
REQ-009 Port MISO  output  1  serial data to the controller, MSB first.
REQ-010 Port rx_data  output  16  last complete word received.
REQ-011 Port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-012 Port busy  output  1  high while a transfer is in progress.

Function
REQ-013 SCK, SS and MOSI SHALL each pass through a 2-flop synchronizer before use; SCK edges SHALL be detected by comparing the synchronized value with its previous value.
REQ-014 Leading edge = SCK transition away from CKP, trailing edge = transition back to CKP; sample edge = leading if CPH=0, trailing if CPH=1; shift edge = the other edge.
REQ-015 SCK frequency is at most clk/8; behaviour above that rate is undefined.
REQ-016 FSM states SHALL be IDLE, TRANSFER, DONE.
REQ-017 IDLE: MISO=0, busy=0, bit counter=0; on detected falling edge of synchronized SS, load tx_data into tx shift register and enter TRANSFER.
REQ-018 TRANSFER entry with CPH=0: MISO SHALL present tx_data[15] in the cycle after the SS falling edge is detected.
REQ-019 TRANSFER entry with CPH=1: MISO SHALL present tx_data[15] after the first shift (leading) edge.
REQ-020 On each sample edge: shift synchronized MOSI into rx shift register LSB and increment the 4-bit bit counter.
REQ-021 On each shift edge (excluding the first leading edge when CPH=1): shift tx register left, MISO takes the next bit.
REQ-022 On the 16th sample edge: counter wraps to 0, enter DONE.
REQ-023 DONE (one cycle): rx_data <= assembled word, rx_valid=1, tx register reloads from tx_data; return to TRANSFER if SS still low, else IDLE.
REQ-024 Back-to-back words under continuous SS low SHALL be supported with no gap; MISO of the next word begins with the reloaded tx_data[15].
REQ-025 SS deasserted mid-word (counter 1..15): discard partial word, no rx_valid, rx_data unchanged, go IDLE next cycle.
REQ-026 16th sample edge and SS deassertion detected in the same cycle: word SHALL complete (DONE, rx_valid) and then go IDLE.
REQ-027 busy SHALL be 1 in TRANSFER and DONE, 0 in IDLE.
REQ-028 SCK edges while SS high SHALL be ignored.

Reset
REQ-029 While reset=0 at a clk edge: state IDLE, MISO=0, rx_data=16'h0000, rx_valid=0, busy=0, counter=0, shift registers 0.
REQ-030 Synchronizers SHALL reset to idle levels: SCK stages=CKP, SS stages=1, MOSI stages=0.
REQ-031 Reset asserted mid-transfer SHALL abort the word with no rx_valid; the first transfer after reset release requires a fresh SS falling edge.

Verification
REQ-032 Mode 0, tx_data=16'hA5C3, controller sends 16'h1234 -> rx_data=16'h1234, one rx_valid pulse, MISO stream = A5C3 MSB first.
REQ-033 Mode 3 (CKP=1,CPH=1), controller sends 16'hFFFF then 16'h0001 with SS held low, tx_data=16'h8001 -> two rx_valid pulses, rx_data 16'hFFFF then 16'h0001, MISO 8001 twice.
REQ-034 Mode 0, SS raised after 9 bits of 16'hBEEF -> no rx_valid, rx_data keeps previous value, busy=0 within 4 clk.
REQ-035 SCK toggled 16 times with SS high -> no rx_valid, busy=0, MISO=0.
REQ-036 reset=0 asserted after 8 bits -> all outputs at reset values next cycle; subsequent full word 16'h00FF received correctly.
